// File: rtl/serial_sum_collector_if.sv
// Bus between the bit-serial adder's carry stage and the word collector:
// the serial input stream, the parallel result handshake and status.
interface serial_sum_collector_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             clear;
  logic             sin_bit;
  logic             sin_carry;
  logic             sin_valid;
  logic             sin_ready;
  logic [WIDTH-1:0] sum_out;
  logic             cout;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    bit_cnt;

  modport master (
    output clear, sin_bit, sin_carry, sin_valid, out_ready,
    input  sin_ready, sum_out, cout, ovf, out_valid, bit_cnt
  );

  modport slave (
    input  clear, sin_bit, sin_carry, sin_valid, out_ready,
    output sin_ready, sum_out, cout, ovf, out_valid, bit_cnt
  );
endinterface

// File: rtl/serial_sum_collector.sv
// Collects an LSB-first stream of sum bits and carries into a WIDTH-bit
// result with carry-out and signed overflow, held until downstream takes it.
module serial_sum_collector #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_sum_collector_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [CW-1:0]    cnt_reg;
  logic             prev_carry_reg;
  logic             cout_reg;
  logic             ovf_reg;

  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] shift_next;

  // Ready is decoded from state only, so out_ready never reaches sin_ready.
  assign accept     = bus.sin_valid && (state_reg == COLLECT);
  assign last_bit   = (cnt_reg == CW'(WIDTH - 1));
  assign shift_next = {bus.sin_bit, shift_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= COLLECT;
      shift_reg      <= '0;
      sum_reg        <= '0;
      cnt_reg        <= '0;
      prev_carry_reg <= 1'b0;
      cout_reg       <= 1'b0;
      ovf_reg        <= 1'b0;
    end else if (bus.clear) begin
      // Flush the word in flight; the last delivered result stays visible.
      state_reg      <= COLLECT;
      shift_reg      <= '0;
      cnt_reg        <= '0;
      prev_carry_reg <= 1'b0;
    end else begin
      case (state_reg)
        COLLECT: begin
          if (accept) begin
            prev_carry_reg <= bus.sin_carry;
            if (last_bit) begin
              sum_reg   <= shift_next;
              cout_reg  <= bus.sin_carry;
              ovf_reg   <= prev_carry_reg ^ bus.sin_carry;
              shift_reg <= '0;
              cnt_reg   <= '0;
              state_reg <= HOLD;
            end else begin
              shift_reg <= shift_next;
              cnt_reg   <= cnt_reg + CW'(1);
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_reg <= COLLECT;
          end
        end
        default: state_reg <= COLLECT;
      endcase
    end
  end

  assign bus.sin_ready = (state_reg == COLLECT);
  assign bus.out_valid = (state_reg == HOLD);
  assign bus.sum_out   = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.bit_cnt   = cnt_reg;
endmodule

// File: doc/serial_sum_collector.md
Name: serial_sum_collector

Overview:
Receiving end of the bit-serial adder datapath. Consumes the LSB-first stream of sum bits plus the per-bit carry-out from the carry flip-flop stage, and assembles them into a parallel WIDTH-bit result with final carry and signed-overflow flag. Presents the result on a valid/ready output handshake and back-pressures the serial stream while a result is pending.

Parameters:
WIDTH, 8, operand/result width in bits (≥2); number of serial bits per word.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst_n  input  1  asynchronous active-low reset.
clear  input  1  synchronous flush; drops any partial word and any pending result.
sin_bit  input  1  serial sum bit, LSB first.
sin_carry  input  1  carry-out of the bit position carried by sin_bit.
sin_valid  input  1  sin_bit/sin_carry are valid this cycle.
sin_ready  output  1  collector accepts a bit this cycle.
sum_out  output  WIDTH  assembled sum; bit i = i-th accepted bit.
cout  output  1  carry-out of MSB position (sin_carry of last bit).
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.
out_valid  output  1  sum_out/cout/ovf hold a complete result.
out_ready  input  1  downstream accepts the result.
bit_cnt  output  clog2(WIDTH+1)  bits accepted in current word (debug/status).

Behaviour:
- Reset (rst_n low, async): state COLLECT, bit_cnt=0, shift register=0, sum_out=0, cout=0, ovf=0, out_valid=0, sin_ready=1 (once rst_n released). Reset mid-word discards the partial word; no result is produced.
- Accept = sin_valid & sin_ready. Gaps in sin_valid are allowed; no state change on cycles without accept.
- States: COLLECT (sin_ready=1, out_valid=0) and HOLD (sin_ready=0, out_valid=1).
- COLLECT, on accept: sin_bit shifted into the shift register MSB end (after WIDTH accepts, first bit sits at bit 0); bit_cnt+1; sin_carry registered as prev_carry.
- On the accept where bit_cnt == WIDTH-1 (Nth bit): next cycle sum_out = full assembled word, cout = sin_carry of that bit, ovf = prev_carry (carry of bit WIDTH-2) XOR sin_carry, bit_cnt=0, state HOLD. Latency: out_valid high the cycle after the Nth bit is accepted.
- HOLD: outputs stable; sin_ready=0, so no bits accepted regardless of sin_valid. On out_valid & out_ready: next cycle state COLLECT, out_valid=0, sin_ready=1. sum_out/cout/ovf retain the last result until the next completion overwrites them. Minimum word period is therefore WIDTH+1 cycles.
- sin_ready is a registered/state-decoded output with no combinational path from out_ready; a bit cannot be accepted in the same cycle a result is consumed.
- clear (sync) has priority over all handshakes: next cycle COLLECT, bit_cnt=0, shift register=0, out_valid=0; sum_out/cout/ovf are not modified. clear coincident with an Nth-bit accept: the word is discarded and no result is produced.
- bit_cnt never exceeds WIDTH-1 in COLLECT; it reads 0 throughout HOLD.

Test Plan:
- WIDTH=8, stream 0x5A+0x3C: sum bits LSB-first 0,1,1,0,1,0,0,1 with carries 0,0,0,1,1,1,1,0, sin_valid continuous, out_ready=1 -> out_valid pulses 1 cycle after the 8th bit; sum_out=0x96, cout=0, ovf=1; sin_ready low exactly that cycle.
- Stream 0xFF+0x01: bits 0×8, carries 1×8 -> sum_out=0x00, cout=1, ovf=0.
- Back-pressure: out_ready=0 for 5 cycles after completion while sin_valid=1 -> out_valid and sum_out stable, sin_ready=0, no bits consumed; the next word starts only after the out_ready handshake and assembles correctly.
- Gapped input: 0x96 stream with sin_valid toggling 1,0,1,0... -> identical result to the continuous case; bit_cnt advances only on accepts.
- clear after 4 accepted bits, then a full 0x01+0x01 stream (bits 0,1,0..., carries 1,0,...) -> sum_out=0x02, cout=0, ovf=0; no spurious out_valid from the aborted word.
- rst_n pulsed low asynchronously mid-word and during HOLD -> out_valid=0, sum_out=0, bit_cnt=0 immediately; the next full word completes correctly.
